ps2_kbd_tx: RTL and testbench

PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

---
 rtl/ps2_kbd_tx.sv | 178 +++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter. It queues scan codes in a 4-deep FIFO and
// shifts each one out as an 11-bit PS/2 frame on device-driven clock/data.
// Consecutive frames are separated by a fixed idle gap.
module ps2_kbd_tx #(
    parameter int unsigned HALF_PERIOD = 2000,
    parameter int unsigned GAP_CYCLES  = 4000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_action,
    input  logic [7:0] scan_code,
    output logic       ps2_clk,
    output logic       ps2_dat,
    output logic       busy,
    output logic       overflow
);

    localparam logic [15:0] HP_LAST  = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [15:0] hp_cnt_q, hp_cnt_d;
    logic        phase_q, phase_d;      // 0: clock-high half, 1: clock-low half
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        ps2_clk_q, ps2_clk_d;
    logic        ps2_dat_q, ps2_dat_d;
    logic        busy_q;
    logic        overflow_q;
    logic        pop;

    logic [7:0]  fifo_mem_q [4];
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        push_ok;
    logic        push_drop;
    logic [10:0] frame;

    // FIFO bookkeeping: a pop in the same cycle frees a slot for a push on full.
    always_comb begin
        push_ok   = key_action && ((count_q != 3'd4) || pop);
        push_drop = key_action && (count_q == 3'd4) && !pop;
        rd_ptr_d  = rd_ptr_q + 2'(pop);
        wr_ptr_d  = wr_ptr_q + 2'(push_ok);
        count_d   = count_q + 3'(push_ok) - 3'(pop);
    end

    // FIFO storage; stale entries are harmless because the pointers reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset && push_ok) begin
            fifo_mem_q[wr_ptr_q] <= scan_code;
        end
    end

    // FIFO pointers, count and the overflow pulse.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= push_drop;
        end
    end

    // State register, frame counters and registered line outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
            hp_cnt_q  <= '0;
            phase_q   <= 1'b0;
            gap_cnt_q <= '0;
            shift_q   <= '0;
            ps2_clk_q <= 1'b1;
            ps2_dat_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            hp_cnt_q  <= hp_cnt_d;
            phase_q   <= phase_d;
            gap_cnt_q <= gap_cnt_d;
            shift_q   <= shift_d;
            ps2_clk_q <= ps2_clk_d;
            ps2_dat_q <= ps2_dat_d;
            // Lines lag the state by one edge, so busy uses the current state
            // to stay high until the last gap cycle has appeared on the lines.
            busy_q    <= (state_q != S_IDLE) || (count_d != 3'd0);
        end
    end

    // Next-state logic. A byte waiting at the end of the gap is popped
    // straight into SEND so the idle stretch is exactly GAP_CYCLES long.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        hp_cnt_d  = hp_cnt_q;
        phase_d   = phase_q;
        gap_cnt_d = gap_cnt_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != 3'd0) begin
                    pop       = 1'b1;
                    shift_d   = fifo_mem_q[rd_ptr_q];
                    state_d   = S_SEND;
                    bit_idx_d = '0;
                    hp_cnt_d  = '0;
                    phase_d   = 1'b0;
                end
            end
            S_SEND: begin
                if (hp_cnt_q == HP_LAST) begin
                    hp_cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_idx_q == 4'd10) begin
                            state_d   = S_GAP;
                            gap_cnt_d = '0;
                        end else begin
                            bit_idx_d = bit_idx_q + 4'd1;
                        end
                    end
                end else begin
                    hp_cnt_d = hp_cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (count_q != 3'd0) begin
                        pop       = 1'b1;
                        shift_d   = fifo_mem_q[rd_ptr_q];
                        state_d   = S_SEND;
                        bit_idx_d = '0;
                        hp_cnt_d  = '0;
                        phase_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: frame is {stop, odd parity, data, start}, sent LSB first.
    always_comb begin
        frame     = {1'b1, ~^shift_q, shift_q, 1'b0};
        ps2_clk_d = 1'b1;
        ps2_dat_d = 1'b1;
        if (state_q == S_SEND) begin
            ps2_clk_d = ~phase_q;
            if (bit_idx_q <= 4'd10) begin
                ps2_dat_d = frame[bit_idx_q];
            end
        end
    end

    assign ps2_clk  = ps2_clk_q;
    assign ps2_dat  = ps2_dat_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Testbench for ps2_kbd_tx. A line monitor decodes frames from the PS/2 pins
// and measures frame length, inter-frame gap and busy release timing. The
// directed sequence compares those results with frames derived from the
// scan codes that were pushed.
module tb_ps2_kbd_tx;

    localparam int HP    = 4;
    localparam int G     = 8;
    localparam int FRAME = 22 * HP;

    logic       CLOCK_50   = 1'b0;
    logic       reset      = 1'b1;
    logic       key_action = 1'b0;
    logic [7:0] scan_code  = '0;
    logic       ps2_clk, ps2_dat, busy, overflow;

    int vectors     = 0;
    int miscompares = 0;

    ps2_kbd_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(G)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .key_action(key_action),
        .scan_code (scan_code),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // ---------------- line monitor (samples on the falling clock edge) ----
    int          cyc = 0, start_cyc = 0, end_cyc = 0, cur_gap = -1, nbits = 0;
    int          frames_done = 0, starts = 0, ovf_cnt = 0, dat_viol = 0;
    bit          in_frame = 1'b0, have_end = 1'b0;
    logic        prev_clk = 1'b1, prev_dat = 1'b1, prev_busy = 1'b0;
    logic [10:0] bits_acc = '0;
    logic [10:0] frames[$];
    int          lens[$], gaps[$], busy_falls[$];

    always @(negedge CLOCK_50) begin
        cyc++;
        if (reset) begin
            in_frame = 1'b0;
            nbits    = 0;
            have_end = 1'b0;
        end else begin
            if (!in_frame && prev_dat === 1'b1 && ps2_dat === 1'b0 && ps2_clk === 1'b1) begin
                in_frame  = 1'b1;
                nbits     = 0;
                start_cyc = cyc;
                starts++;
                cur_gap   = have_end ? cyc - end_cyc : -1;
            end
            if (in_frame && prev_clk === 1'b1 && ps2_clk === 1'b0 && nbits < 11) begin
                bits_acc[nbits] = ps2_dat;
                nbits++;
            end
            if (in_frame && nbits == 11 && prev_clk === 1'b0 && ps2_clk === 1'b1) begin
                frames.push_back(bits_acc);
                lens.push_back(cyc - start_cyc);
                gaps.push_back(cur_gap);
                end_cyc  = cyc;
                have_end = 1'b1;
                in_frame = 1'b0;
                nbits    = 0;
                frames_done++;
            end
            if (ps2_dat !== prev_dat && ps2_clk !== 1'b1) dat_viol++;
            if (overflow === 1'b1) ovf_cnt++;
            if (prev_busy === 1'b1 && busy === 1'b0)
                busy_falls.push_back(have_end ? cyc - end_cyc : -1);
        end
        prev_clk  = ps2_clk;
        prev_dat  = ps2_dat;
        prev_busy = busy;
    end

    // ---------------- reference model ------------------------------------
    // Bit i of the result is the i-th bit seen on a ps2_clk falling edge.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f    = '0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // ---------------- helpers ---------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_now(input logic [7:0] b);
        key_action = 1'b1;
        scan_code  = b;
        @(negedge CLOCK_50);
        key_action = 1'b0;
    endtask

    task automatic push_burst(input logic [7:0] codes[$]);
        foreach (codes[i]) begin
            key_action = 1'b1;
            scan_code  = codes[i];
            @(negedge CLOCK_50);
        end
        key_action = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        chk({tag, "_idle_timeout"}, 32'(n < 5000), 32'd1);
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic check_frames(input string tag, input int n0, input logic [7:0] exp[$]);
        chk({tag, "_nframes"}, 32'(frames.size() - n0), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (n0 + i < frames.size()) begin
                chk($sformatf("%s_bits%0d", tag, i), 32'(frames[n0 + i]), 32'(model_frame(exp[i])));
                chk($sformatf("%s_len%0d", tag, i), 32'(lens[n0 + i]), 32'(FRAME));
                if (i > 0) chk($sformatf("%s_gap%0d", tag, i), 32'(gaps[n0 + i]), 32'(G));
            end
        end
    endtask

    // ---------------- directed sequence -----------------------------------
    initial begin
        logic [7:0] q[$];
        logic [7:0] e[$];
        logic [7:0] r;
        int n0, ovf0, fd0, s0, n;

        // Reset state
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_clk", 32'(ps2_clk), 32'd1);
        chk("rst_dat", 32'(ps2_dat), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);

        // Single 0x1C frame: latency, bit pattern, length, busy release
        n0 = frames.size();
        push_now(8'h1C);
        chk("s1_busy_up", 32'(busy), 32'd1);
        @(posedge CLOCK_50); #1;
        chk("s1_lat_e1", 32'(ps2_dat), 32'd1);
        @(posedge CLOCK_50); #1;
        chk("s1_lat_e2", 32'(ps2_dat), 32'd0);
        wait_idle("s1");
        e.delete(); e.push_back(8'h1C);
        check_frames("s1", n0, e);
        if (frames.size() > n0) chk("s1_pattern", 32'(frames[n0]), 32'h438);
        if (busy_falls.size() > 0) chk("s1_busy_fall", 32'(busy_falls[$]), 32'(G));

        // 0x00 then 0xFF back-to-back
        n0 = frames.size();
        q.delete(); q.push_back(8'h00); q.push_back(8'hFF);
        push_burst(q);
        wait_idle("s2");
        check_frames("s2", n0, q);
        if (busy_falls.size() > 0) chk("s2_busy_fall", 32'(busy_falls[$]), 32'(G));

        // Break sequence pushed while a frame is on the wire
        n0   = frames.size();
        ovf0 = ovf_cnt;
        r    = 8'($urandom);
        push_now(r);
        repeat (20) @(negedge CLOCK_50);
        push_now(8'hF0);
        repeat (7) @(negedge CLOCK_50);
        push_now(8'h1C);
        wait_idle("s3");
        e.delete(); e.push_back(r); e.push_back(8'hF0); e.push_back(8'h1C);
        check_frames("s3", n0, e);
        chk("s3_ovf", 32'(ovf_cnt - ovf0), 32'd0);

        // Six strobes in six consecutive cycles: the sixth is dropped
        n0   = frames.size();
        ovf0 = ovf_cnt;
        q.delete();
        for (int i = 1; i <= 6; i++) q.push_back(8'(i));
        push_burst(q);
        wait_idle("s4");
        void'(q.pop_back());
        check_frames("s4", n0, q);
        chk("s4_ovf", 32'(ovf_cnt - ovf0), 32'd1);

        // Push on a full FIFO in the same cycle as the gap-end pop
        n0   = frames.size();
        ovf0 = ovf_cnt;
        fd0  = frames_done;
        e.delete();
        e.push_back(8'($urandom));
        push_now(e[0]);
        repeat (10) @(negedge CLOCK_50);
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        push_burst(q);
        foreach (q[i]) e.push_back(q[i]);
        n = 0;
        while (frames_done == fd0 && n < 2000) begin
            @(posedge CLOCK_50);
            n++;
        end
        chk("s5_frame_timeout", 32'(n < 2000), 32'd1);
        repeat (G - 2) @(negedge CLOCK_50);
        e.push_back(8'($urandom));
        push_now(e[5]);
        wait_idle("s5");
        check_frames("s5", n0, e);
        chk("s5_ovf", 32'(ovf_cnt - ovf0), 32'd0);

        // Reset in the middle of bit 5 aborts the frame and flushes the FIFO
        fd0 = frames_done;
        push_now(8'($urandom));
        push_now(8'($urandom));
        n = 0;
        while (nbits != 5 && n < 2000) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        chk("s6_bit_timeout", 32'(n < 2000), 32'd1);
        repeat (HP + 2) @(negedge CLOCK_50);
        reset      = 1'b1;
        key_action = 1'b1;
        scan_code  = 8'hAA;
        @(posedge CLOCK_50); #1;
        chk("s6_clk", 32'(ps2_clk), 32'd1);
        chk("s6_dat", 32'(ps2_dat), 32'd1);
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_ovf", 32'(overflow), 32'd0);
        @(negedge CLOCK_50);
        reset      = 1'b0;
        key_action = 1'b0;
        s0 = starts;
        repeat (300) @(negedge CLOCK_50);
        chk("s6_no_start", 32'(starts), 32'(s0));
        chk("s6_no_frame", 32'(frames_done), 32'(fd0));
        chk("s6_idle_busy", 32'(busy), 32'd0);
        chk("s6_idle_dat", 32'(ps2_dat), 32'd1);

        chk("dat_change_when_clk_low", 32'(dat_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
